mealy_seq_detector: RTL and testbench



---
 rtl/fsm_pkg.sv | 17 +
 rtl/sat_counter.sv | 29 ++
 rtl/mealy_seq_detector.sv | 73 +++++++
 tb/tb_mealy_seq_detector.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_pkg.sv
// Helpers shared by the serial FSM blocks.
package fsm_pkg;

    // Returns the number of bits needed to encode the values 0 .. value-1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result++;
            v = v >>> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear, reusable across the FSM blocks.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_cnt;

    // Clear wins over increment; at the top value the count simply holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/mealy_seq_detector.sv
// Serial W-bit pattern detector: Mealy match flag, optional overlap, bit-valid
// qualifier, synchronous clear and a saturating match counter.
module mealy_seq_detector
    import fsm_pkg::*;
#(
    parameter int             W       = 2,
    parameter logic [W-1:0]   PATTERN = 2'b10,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    input  logic             clr,
    output logic             y,
    output logic             primed,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int              FILL_W   = clog2(W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(W - 1);

    if (W < 2 || W > 32) begin : g_bad_w
        $error("mealy_seq_detector: W must be in 2..32");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("mealy_seq_detector: CNT_W must be at least 1");
    end

    logic [W-2:0]      r_hist;
    logic [FILL_W-1:0] r_fill;
    logic [W-1:0]      w_window;
    logic              w_full;
    logic              w_hit;

    // The candidate window is the stored history with the live bit appended.
    assign w_window = {r_hist, x};
    assign w_full   = (r_fill == FILL_MAX);
    assign w_hit    = rst & en & ~clr & w_full & (w_window == PATTERN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (clr) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (en) begin
            r_hist <= w_window[W-2:0];
            // Without overlap a match consumes the window, so counting restarts.
            if (w_hit && !OVERLAP) begin
                r_fill <= '0;
            end else if (!w_full) begin
                r_fill <= r_fill + FILL_W'(1);
            end
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (w_hit),
        .cnt (match_cnt)
    );

    assign y      = w_hit;
    assign primed = w_full;

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Self-checking bench: four detector configurations share one stimulus stream
// and are compared against a bit-log reference model.
module tb_mealy_seq_detector;

    localparam int NDUT = 4;
    localparam int W_C   [NDUT] = '{4, 4, 2, 2};
    localparam int PAT_C [NDUT] = '{11, 11, 2, 2};
    localparam bit OV_C  [NDUT] = '{1'b1, 1'b0, 1'b1, 1'b1};
    localparam int MAX_C [NDUT] = '{255, 255, 255, 3};

    logic clk;
    logic rst;
    logic en;
    logic x;
    logic clr;

    logic       y0, y1, y2, y3;
    logic       p0, p1, p2, p3;
    logic [7:0] c0, c1, c2;
    logic [1:0] c3;

    logic        y_a   [NDUT];
    logic        p_a   [NDUT];
    logic [31:0] cnt_a [NDUT];

    bit log_q [$];
    int start_i [NDUT];
    int cnt_m [NDUT];
    bit exp_y [NDUT];
    int n_checks;
    int n_fail;

    mealy_seq_detector #(.W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
        .clk(clk), .rst(rst), .en(en), .x(x), .clr(clr), .y(y0), .primed(p0), .match_cnt(c0));
    mealy_seq_detector #(.W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_no (
        .clk(clk), .rst(rst), .en(en), .x(x), .clr(clr), .y(y1), .primed(p1), .match_cnt(c1));
    mealy_seq_detector u_def (
        .clk(clk), .rst(rst), .en(en), .x(x), .clr(clr), .y(y2), .primed(p2), .match_cnt(c2));
    mealy_seq_detector #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .en(en), .x(x), .clr(clr), .y(y3), .primed(p3), .match_cnt(c3));

    always_comb begin
        y_a[0] = y0;  y_a[1] = y1;  y_a[2] = y2;  y_a[3] = y3;
        p_a[0] = p0;  p_a[1] = p1;  p_a[2] = p2;  p_a[3] = p3;
        cnt_a[0] = {24'b0, c0};
        cnt_a[1] = {24'b0, c1};
        cnt_a[2] = {24'b0, c2};
        cnt_a[3] = {30'b0, c3};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the log holds every valid bit since reset/clr; each
    // configuration remembers where its current window count started.
    function automatic bit model_hit(input int k);
        int avail;
        bit b;
        if (rst !== 1'b1 || en !== 1'b1 || clr !== 1'b0) return 1'b0;
        avail = log_q.size() - start_i[k] + 1;
        if (avail < W_C[k]) return 1'b0;
        for (int j = 0; j < W_C[k]; j++) begin
            b = (j == 0) ? x : log_q[log_q.size() - j];
            if (b != bit'((PAT_C[k] >> j) & 1)) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit model_primed(input int k);
        return (log_q.size() - start_i[k]) >= (W_C[k] - 1);
    endfunction

    task automatic model_reset();
        log_q.delete();
        for (int k = 0; k < NDUT; k++) begin
            start_i[k] = 0;
            cnt_m[k]   = 0;
        end
    endtask

    task automatic drive(input bit e, input bit b, input bit c);
        @(negedge clk);
        en  = e;
        x   = b;
        clr = c;
        #1;
        for (int k = 0; k < NDUT; k++) exp_y[k] = model_hit(k);
    endtask

    task automatic clock_edge();
        bit hit_now [NDUT];
        @(posedge clk);
        for (int k = 0; k < NDUT; k++) hit_now[k] = model_hit(k);
        if (rst === 1'b1) begin
            if (clr) begin
                model_reset();
            end else if (en) begin
                log_q.push_back(x);
                for (int k = 0; k < NDUT; k++) begin
                    if (hit_now[k]) begin
                        if (cnt_m[k] < MAX_C[k]) cnt_m[k]++;
                        if (!OV_C[k]) start_i[k] = log_q.size();
                    end
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b1; x = 1'b1; clr = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            n_checks++;
            if (y_a[k] !== 1'b0 || cnt_a[k] !== 32'd0 || p_a[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset dut%0d: y=%b cnt=%0d primed=%b, want 0/0/0", k, y_a[k], cnt_a[k], p_a[k]);
            end
        end
        en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        $display("reset: released");
    endtask

    task automatic test_overlap();
        bit seq [7] = '{1, 0, 1, 1, 0, 1, 1};
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, seq[i], 1'b0);
            for (int k = 0; k < NDUT; k++) begin
                n_checks++;
                if (y_a[k] !== exp_y[k]) begin
                    n_fail++;
                    $display("FAIL overlap y dut%0d bit%0d: got %b want %b", k, i, y_a[k], exp_y[k]);
                end
            end
            n_checks++;
            if (y_a[0] !== bit'(i == 3 || i == 6) || y_a[1] !== bit'(i == 3)) begin
                n_fail++;
                $display("FAIL overlap spec y bit%0d: got ov=%b no=%b", i, y_a[0], y_a[1]);
            end
            clock_edge();
            for (int k = 0; k < NDUT; k++) begin
                n_checks++;
                if (cnt_a[k] !== cnt_m[k] || p_a[k] !== model_primed(k)) begin
                    n_fail++;
                    $display("FAIL overlap state dut%0d bit%0d: cnt=%0d primed=%b, want cnt=%0d primed=%b",
                             k, i, cnt_a[k], p_a[k], cnt_m[k], model_primed(k));
                end
            end
            $display("overlap: bit%0d x=%b y_ov=%b y_no=%b", i, seq[i], y_a[0], y_a[1]);
        end
        n_checks++;
        if (cnt_a[0] !== 32'd2 || cnt_a[1] !== 32'd1) begin
            n_fail++;
            $display("FAIL overlap final count: got ov=%0d no=%0d want 2/1", cnt_a[0], cnt_a[1]);
        end
    endtask

    task automatic test_en_gaps();
        drive(1'b0, 1'b0, 1'b1);
        clock_edge();
        drive(1'b1, 1'b1, 1'b0);
        clock_edge();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0);
            for (int k = 0; k < NDUT; k++) begin
                n_checks++;
                if (y_a[k] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL en_gap y dut%0d cycle%0d: got %b want 0", k, i, y_a[k]);
                end
            end
            clock_edge();
        end
        drive(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (y_a[2] !== 1'b1 || y_a[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL en_gap final y: got def=%b sat=%b want 1/1", y_a[2], y_a[3]);
        end
        clock_edge();
        for (int k = 0; k < NDUT; k++) begin
            n_checks++;
            if (cnt_a[k] !== cnt_m[k] || p_a[k] !== model_primed(k)) begin
                n_fail++;
                $display("FAIL en_gap state dut%0d: cnt=%0d primed=%b, want cnt=%0d primed=%b",
                         k, cnt_a[k], p_a[k], cnt_m[k], model_primed(k));
            end
        end
        $display("en_gaps: def cnt=%0d", cnt_a[2]);
    endtask

    task automatic test_saturation();
        int sat_exp [5] = '{1, 2, 3, 3, 3};
        drive(1'b0, 1'b0, 1'b1);
        clock_edge();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            clock_edge();
            drive(1'b1, 1'b0, 1'b0);
            n_checks++;
            if (y_a[3] !== 1'b1) begin
                n_fail++;
                $display("FAIL saturation y pair%0d: got %b want 1", i, y_a[3]);
            end
            clock_edge();
            n_checks++;
            if (cnt_a[3] !== sat_exp[i] || cnt_a[2] !== cnt_m[2]) begin
                n_fail++;
                $display("FAIL saturation cnt pair%0d: got sat=%0d def=%0d want %0d/%0d",
                         i, cnt_a[3], cnt_a[2], sat_exp[i], cnt_m[2]);
            end
            $display("saturation: pair%0d sat_cnt=%0d", i, cnt_a[3]);
        end
    endtask

    task automatic test_async_reset();
        bit seq [4] = '{1, 0, 1, 1};
        drive(1'b0, 1'b0, 1'b1);
        clock_edge();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, seq[i], 1'b0);
            clock_edge();
        end
        drive(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (y_a[0] !== 1'b1 || y_a[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset pre-drop y: got ov=%b no=%b want 1/1", y_a[0], y_a[1]);
        end
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < NDUT; k++) begin
            n_checks++;
            if (y_a[k] !== 1'b0 || cnt_a[k] !== 32'd0 || p_a[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL async_reset drop dut%0d: y=%b cnt=%0d primed=%b want 0/0/0", k, y_a[k], cnt_a[k], p_a[k]);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (y_a[0] !== 1'b0 || y_a[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset first bit y: got ov=%b no=%b want 0/0", y_a[0], y_a[1]);
        end
        clock_edge();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, seq[i], 1'b0);
            for (int k = 0; k < NDUT; k++) begin
                n_checks++;
                if (y_a[k] !== exp_y[k]) begin
                    n_fail++;
                    $display("FAIL async_reset y dut%0d bit%0d: got %b want %b", k, i, y_a[k], exp_y[k]);
                end
            end
            n_checks++;
            if (y_a[0] !== bit'(i == 3) || y_a[1] !== bit'(i == 3)) begin
                n_fail++;
                $display("FAIL async_reset spec y bit%0d: got ov=%b no=%b", i, y_a[0], y_a[1]);
            end
            clock_edge();
        end
        n_checks++;
        if (cnt_a[0] !== 32'd1 || cnt_a[1] !== 32'd1) begin
            n_fail++;
            $display("FAIL async_reset count: got ov=%0d no=%0d want 1/1", cnt_a[0], cnt_a[1]);
        end
        $display("async_reset: ov cnt=%0d no cnt=%0d", cnt_a[0], cnt_a[1]);
    endtask

    task automatic test_clr_collision();
        drive(1'b1, 1'b1, 1'b0);
        clock_edge();
        drive(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < NDUT; k++) begin
            n_checks++;
            if (y_a[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL clr_collision y dut%0d: got %b want 0", k, y_a[k]);
            end
        end
        clock_edge();
        for (int k = 0; k < NDUT; k++) begin
            n_checks++;
            if (cnt_a[k] !== 32'd0 || p_a[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL clr_collision state dut%0d: cnt=%0d primed=%b want 0/0", k, cnt_a[k], p_a[k]);
            end
        end
        drive(1'b1, 1'b1, 1'b0);
        clock_edge();
        drive(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (y_a[2] !== 1'b1 || y_a[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_collision rematch y: got def=%b sat=%b want 1/1", y_a[2], y_a[3]);
        end
        clock_edge();
        $display("clr_collision: def cnt=%0d", cnt_a[2]);
    endtask

    task automatic test_random();
        bit e, b, c;
        int hits;
        hits = 0;
        for (int i = 0; i < 400; i++) begin
            e = ($urandom_range(0, 3) != 0);
            b = 1'($urandom_range(0, 1));
            c = ($urandom_range(0, 31) == 0);
            drive(e, b, c);
            for (int k = 0; k < NDUT; k++) begin
                n_checks++;
                if (y_a[k] !== exp_y[k]) begin
                    n_fail++;
                    $display("FAIL random y dut%0d cycle%0d: got %b want %b", k, i, y_a[k], exp_y[k]);
                end
                if (exp_y[k]) hits++;
            end
            clock_edge();
            for (int k = 0; k < NDUT; k++) begin
                n_checks++;
                if (cnt_a[k] !== cnt_m[k] || p_a[k] !== model_primed(k)) begin
                    n_fail++;
                    $display("FAIL random state dut%0d cycle%0d: cnt=%0d primed=%b, want cnt=%0d primed=%b",
                             k, i, cnt_a[k], p_a[k], cnt_m[k], model_primed(k));
                end
            end
            $display("random: cycle%0d en=%b x=%b clr=%b y=%b%b%b%b", i, e, b, c, y_a[0], y_a[1], y_a[2], y_a[3]);
        end
        $display("random: %0d expected hits across configurations", hits);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_overlap();
        test_en_gaps();
        test_saturation();
        test_async_reset();
        test_clr_collision();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
